// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/ack single-port memory between IF fetches and MEM loads/stores
// Ports:
//   clk_i, rst_i (async, active-low)
//   if_req_i/if_addr_i -> if_data_o/if_done_o     instruction fetch side
//   d_read_i/d_write_i/d_addr_i/d_wdata_i -> d_rdata_o/d_done_o   data side
//   flush_i                                        cancels the current fetch
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_ack_i/mem_rdata_i   memory port
//   stall_o                                        freezes pipeline until every active request is served
// Optional: define MEM_ARB_FETCH_HOLD_EN to add a one-entry fetch hold register.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_done_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_done_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, DISCARD} state_t;

    state_t r_state, w_next;
    logic r_if_done, r_d_done, r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_if_data, r_d_rdata;
    logic w_d_pend, w_if_pend, w_idle, w_issue_d, w_if_go, w_issue_f, w_hit, w_ack_f, w_ack_d;
    logic [DATA_W-1:0] w_hold_data;

    assign w_d_pend  = (d_read_i | d_write_i) & ~r_d_done;
    assign w_if_pend = if_req_i & ~r_if_done;
    assign stall_o   = w_if_pend | w_d_pend;
    assign w_idle    = r_state == IDLE;
    assign w_issue_d = w_idle & w_d_pend;
    // a fetch presented together with flush_i is stale; wait for the redirected PC
    assign w_if_go   = w_idle & ~w_d_pend & w_if_pend & ~flush_i;
    assign w_issue_f = w_if_go & ~w_hit;
    // a fetch acked in the same cycle as a flush is dropped just like one in DISCARD
    assign w_ack_f   = (r_state == FETCH) & mem_ack_i & ~flush_i;
    assign w_ack_d   = (r_state == DATA) & mem_ack_i;

`ifdef MEM_ARB_FETCH_HOLD_EN
    logic [ADDR_W-1:0] r_hold_tag;
    logic [DATA_W-1:0] r_hold_data;
    logic r_hold_vld;

    assign w_hit       = w_if_go & r_hold_vld & (if_addr_i == r_hold_tag);
    assign w_hold_data = r_hold_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hold_tag  <= '0;
            r_hold_data <= '0;
            r_hold_vld  <= 1'b0;
        end else if (w_ack_f) begin
            r_hold_tag  <= r_mem_addr;
            r_hold_data <= mem_rdata_i;
            r_hold_vld  <= 1'b1;
        end else if (w_issue_d && d_write_i && d_addr_i == r_hold_tag) begin
            r_hold_vld  <= 1'b0;
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_hold_data = '0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_issue_d ? DATA : w_issue_f ? FETCH : IDLE;
            FETCH:   w_next = mem_ack_i ? IDLE : flush_i ? DISCARD : FETCH;
            default: w_next = mem_ack_i ? IDLE : r_state;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_data   <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_issue_d || w_issue_f) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= w_issue_d & d_write_i;
                r_mem_addr <= w_issue_d ? d_addr_i : if_addr_i;
                if (w_issue_d)
                    r_mem_wdata <= d_wdata_i;
            end else if (mem_ack_i && !w_idle) begin
                r_mem_req <= 1'b0;
            end
            if (w_ack_d && !r_mem_we)
                r_d_rdata <= mem_rdata_i;
            r_if_data <= w_ack_f ? mem_rdata_i : w_hit ? w_hold_data : r_if_data;
            // flags clear when the pipeline advances (stall low) and on flush
            r_if_done <= stall_o & ~flush_i & (r_if_done | w_ack_f | w_hit);
            r_d_done  <= stall_o & (r_d_done | w_ack_d);
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign if_data_o   = r_if_data;
    assign d_rdata_o   = r_d_rdata;
    assign if_done_o   = r_if_done;
    assign d_done_o    = r_d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;
    logic if_req_i, d_read_i, d_write_i, flush_i, mem_ack_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic [31:0] if_data_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic if_done_o, d_done_o, mem_req_o, mem_we_o, stall_o;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef MEM_ARB_FETCH_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    int n_cmp = 0, n_bad = 0;
    int req_cyc, issues, left, fix_lat;
    bit prev_req;
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] exp_ld;

    bit c_if_req, c_rd, c_wr, c_flush;
    logic [31:0] c_pc, c_da, c_dw;

    bit m_busy, m_data, m_we, m_drop, m_if_srv, m_d_srv, h_vld;
    logic [31:0] m_addr, m_wdata, h_tag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : dflt(a);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_we = 0; m_drop = 0; m_if_srv = 0; m_d_srv = 0; h_vld = 0;
        m_addr = 0; m_wdata = 0; h_tag = 0; left = -1; prev_req = 0; exp_ld = 0;
        c_if_req = 0; c_rd = 0; c_wr = 0; c_flush = 0; c_pc = 0; c_da = 0; c_dw = 0;
        if_req_i = 0; d_read_i = 0; d_write_i = 0; flush_i = 0; mem_ack_i = 0;
        if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0;
    endtask

    // one clock: check registered outputs, drive inputs and memory response, advance the model
    task automatic tick(output bit adv, output bit fl);
        bit ack, stl;
        logic [31:0] rd;
        @(negedge clk_i);
        chk("mem_req", mem_req_o, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_we", mem_we_o, m_we);
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("if_done", if_done_o, m_if_srv);
        chk("d_done", d_done_o, m_d_srv);
        ack = 0;
        if (mem_req_o) begin
            req_cyc++;
            if (!prev_req) issues++;
            if (left < 0) left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 2));
            ack = (left == 0);
            left--;
        end else begin
            left = -1;
        end
        prev_req = mem_req_o;
        rd = ack ? bmem_rd(mem_addr_o) : $urandom;
        if (ack && mem_we_o) bmem[mem_addr_o] = mem_wdata_o;
        stl = (c_if_req && !m_if_srv) || ((c_rd || c_wr) && !m_d_srv);
        fl = c_flush && stl && !ack;
        if_req_i = c_if_req; if_addr_i = c_pc;
        d_read_i = c_rd; d_write_i = c_wr; d_addr_i = c_da; d_wdata_i = c_dw;
        flush_i = fl; mem_ack_i = ack; mem_rdata_i = rd;
        #1 chk("stall", stall_o, stl);
        adv = !stl;
        if (m_busy) begin
            if (ack) begin
                m_busy = 0;
                if (m_data) m_d_srv = 1;
                else if (!m_drop && !fl) begin
                    m_if_srv = 1; h_vld = 1; h_tag = m_addr;
                end
            end else if (fl && !m_data) begin
                m_drop = 1;
            end
        end else if ((c_rd || c_wr) && !m_d_srv) begin
            m_busy = 1; m_data = 1; m_addr = c_da; m_we = c_wr; m_wdata = c_dw; m_drop = 0;
            if (c_wr && c_da == h_tag) h_vld = 0;
        end else if (c_if_req && !m_if_srv && !fl) begin
            if (HOLD_ON && h_vld && h_tag == c_pc) m_if_srv = 1;
            else begin
                m_busy = 1; m_data = 0; m_addr = c_pc; m_we = 0; m_drop = 0;
            end
        end
        if (fl) m_if_srv = 0;
        if (adv) begin m_if_srv = 0; m_d_srv = 0; end
    endtask

    // one pipeline cycle: hold inputs until stall drops, then check delivered words
    task automatic pcycle(input bit fr, input logic [31:0] pc, input bit rd, input bit wr,
                          input logic [31:0] da, input logic [31:0] dw, input int fl_at,
                          input logic [31:0] npc);
        bit adv, fl, done_fl;
        int n;
        c_if_req = fr; c_pc = pc; c_rd = rd; c_wr = wr; c_da = da; c_dw = dw;
        adv = 0; done_fl = 0; n = 0;
        while (!adv && n < 64) begin
            c_flush = fl_at >= 0 && n >= fl_at && !done_fl;
            tick(adv, fl);
            if (fl) begin done_fl = 1; c_pc = npc; end
            n++;
        end
        c_flush = 0;
        chk("advance_timeout", adv, 1);
        if (adv) begin
            if (wr) begin
                rmem[da] = dw;
                chk("st_keeps_rdata", d_rdata_o, exp_ld);
            end else if (rd) begin
                exp_ld = rmem_rd(da);
                chk("ld_data", d_rdata_o, exp_ld);
            end
            if (fr) chk("if_data", if_data_o, rmem_rd(c_pc));
        end
    endtask

    initial begin
        bit adv, fl;
        rst_i = 0;
        model_reset();
        fix_lat = -1; req_cyc = 0; issues = 0;
        bmem[32'h10] = 32'h00A00093; rmem[32'h10] = 32'h00A00093;
        bmem[32'h100] = 32'h55; rmem[32'h100] = 32'h55;
        repeat (3) @(negedge clk_i);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_data", if_data_o, 0);
        chk("rst_d_rdata", d_rdata_o, 0);
        chk("rst_if_done", if_done_o, 0);
        chk("rst_d_done", d_done_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_i = 1;

        fix_lat = 2; req_cyc = 0;
        pcycle(1, 32'h10, 0, 0, 0, 0, -1, 0);
        chk("fetch_req_cycles", req_cyc, 3);
        pcycle(0, 32'h14, 0, 0, 0, 0, -1, 0);

        fix_lat = 1; issues = 0;
        pcycle(1, 32'h14, 1, 0, 32'h100, 0, -1, 0);
        chk("ld_fetch_issues", issues, 2);
        pcycle(1, 32'h18, 0, 1, 32'h100, 32'hAB, -1, 0);
        chk("sd_mem_value", bmem_rd(32'h100), 32'hAB);

        fix_lat = 3; issues = 0;
        pcycle(1, 32'h20, 0, 0, 0, 0, 2, 32'h40);
        chk("flush_issues", issues, 2);

        fix_lat = 1; issues = 0;
        pcycle(1, 32'h40, 1, 0, 32'h100, 0, -1, 0);
        chk("hold_refetch_issues", issues, HOLD_ON ? 1 : 2);
        issues = 0;
        pcycle(1, 32'h44, 0, 1, 32'h40, 32'h1234, -1, 0);
        chk("sd_tag_issues", issues, 2);
        issues = 0;
        pcycle(1, 32'h40, 0, 0, 0, 0, -1, 0);
        chk("after_inval_issues", issues, 1);

        fix_lat = 20;
        c_if_req = 1; c_pc = 32'h30; c_rd = 0; c_wr = 0;
        repeat (3) tick(adv, fl);
        #2 rst_i = 0;
        #1;
        chk("rst_mid_mem_req", mem_req_o, 0);
        chk("rst_mid_if_done", if_done_o, 0);
        chk("rst_mid_d_done", d_done_o, 0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1;
        fix_lat = -1;
        pcycle(1, 32'h30, 0, 0, 0, 0, -1, 0);

        for (int i = 0; i < 300; i++) begin
            bit fr, rd, wr;
            int op;
            logic [31:0] pc, da, npc;
            fr = ($urandom % 4) != 0;
            pc = 32'h10 + 4 * $urandom_range(0, 15);
            npc = 32'h10 + 4 * $urandom_range(0, 15);
            op = $urandom % 8;
            rd = op == 1 || op == 2 || op == 7;
            wr = op == 3 || op == 4 || op == 7;
            da = ($urandom % 2) ? 32'h10 + 4 * $urandom_range(0, 15) : 32'h100 + 4 * $urandom_range(0, 15);
            pcycle(fr, pc, rd, wr, da, $urandom, ($urandom % 5 == 0) ? int'($urandom_range(0, 3)) : -1, npc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
